// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing for an ADV7123-style DAC.
// The returned RGB is aligned with the sync and blank outputs.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_DLY = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pix_tick,
  output logic       frame_start,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_tick_q, pix_tick_d;
  logic          vga_clk_q, vga_clk_d;
  logic [9:0]    h_cnt_q, h_cnt_d;
  logic [9:0]    v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_n_q, blank_n_d;
  logic [7:0]    r_q, r_d;
  logic [7:0]    g_q, g_d;
  logic [7:0]    b_q, b_d;

  logic          h_last, v_last;
  logic [2:0]    raw;
  logic [2:0]    tap;

  assign h_last = (h_cnt_q == H_LAST);
  assign v_last = (v_cnt_q == V_LAST);

  always_comb begin
    div_cnt_d  = (div_cnt_q == DIV_LAST) ?
                 '0 : div_cnt_q + DW'(1);
    pix_tick_d = (div_cnt_q == DIV_LAST);
    // registered so its rising edge sits mid-pixel
    vga_clk_d  = (div_cnt_q >= DIV_HALF);
  end

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_tick_q) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // {hs, vs, active} for the pixel at (h_cnt, v_cnt)
  always_comb begin
    raw[2] = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
    raw[1] = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));
    raw[0] = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

  // the output registers are the last delay stage
  if (SYNC_DLY == 1) begin : g_nodly
    assign tap = raw;
  end else begin : g_dly
    logic [2:0] dly_q [SYNC_DLY-1];
    logic [2:0] dly_d [SYNC_DLY-1];

    always_comb begin
      for (int i = 0; i < SYNC_DLY - 1; i++) begin
        dly_d[i] = dly_q[i];
      end
      if (pix_tick_q) begin
        dly_d[0] = raw;
        for (int i = 1; i < SYNC_DLY - 1; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < SYNC_DLY - 1; i++) begin
          dly_q[i] <= 3'b110;
        end
      end else begin
        for (int i = 0; i < SYNC_DLY - 1; i++) begin
          dly_q[i] <= dly_d[i];
        end
      end
    end

    assign tap = dly_q[SYNC_DLY-2];
  end

  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    if (pix_tick_q) begin
      hs_d      = tap[2];
      vs_d      = tap[1];
      blank_n_d = tap[0];
      r_d       = tap[0] ? red_in   : 8'd0;
      g_d       = tap[0] ? green_in : 8'd0;
      b_d       = tap[0] ? blue_in  : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
      vga_clk_q  <= 1'b0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_n_q  <= 1'b0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= pix_tick_d;
      vga_clk_q  <= vga_clk_d;
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      blank_n_q  <= blank_n_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
    end
  end

  assign x           = h_cnt_q;
  assign y           = v_cnt_q;
  assign pix_tick    = pix_tick_q;
  assign frame_start = pix_tick_q && h_last && v_last;
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vga_clk_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a full-size instance for line
// timing and alignment, a shrunken one for frame-level events.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [9:0] d_x, d_y;
  logic       d_pt, d_fs;
  logic [7:0] red_in, green_in, blue_in;
  logic [7:0] d_r, d_g, d_b;
  logic       d_hs, d_vs, d_bn, d_sn, d_vc;

  logic [9:0] s_x, s_y;
  logic       s_pt, s_fs;
  logic [7:0] s_r, s_g, s_b;
  logic       s_hs, s_vs, s_bn, s_sn, s_vc;

  // registered pixel source: RGB for (x, y) one clk after x
  always @(posedge clk) begin
    red_in  <= d_x[7:0];
    blue_in <= d_y[7:0];
  end
  assign green_in = 8'hFF;

  vga_timing_gen u_dut (
    .clk(clk), .rst(rst),
    .x(d_x), .y(d_y),
    .pix_tick(d_pt), .frame_start(d_fs),
    .red_in(red_in), .green_in(green_in),
    .blue_in(blue_in),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
    .vga_hs(d_hs), .vga_vs(d_vs),
    .vga_blank_n(d_bn), .vga_sync_n(d_sn),
    .vga_clk(d_vc)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk(clk), .rst(rst),
    .x(s_x), .y(s_y),
    .pix_tick(s_pt), .frame_start(s_fs),
    .red_in(8'h5A), .green_in(8'hA5),
    .blue_in(8'h3C),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_bn), .vga_sync_n(s_sn),
    .vga_clk(s_vc)
  );

  task automatic check(input string tag,
                       input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  int c, n;
  int xy_bad, rgb_bad, sync_bad, pt_bad, vc_bad;
  int hs_lo, hs_first, bn_cnt, bn_first, bn_last;
  int g_cnt, line_ticks, d_fs_n;
  int s_fs_n, s_fs_first, s_fs_bad;
  int s_vs_lo, s_vs_first;
  int px, py, ppx, ppy;
  bit pact, ehs, evs;

  initial begin
    #45;
    check("rst_x", int'(d_x), 0);
    check("rst_y", int'(d_y), 0);
    check("rst_pt", int'(d_pt), 0);
    check("rst_fs", int'(d_fs), 0);
    check("rst_rgb", int'({d_r, d_g, d_b}), 0);
    check("rst_hs", int'(d_hs), 1);
    check("rst_vs", int'(d_vs), 1);
    check("rst_bn", int'(d_bn), 0);
    check("rst_vclk", int'(d_vc), 0);
    check("sync_n", int'(d_sn), 0);
    rst = 1'b0;

    c = 0; n = 0;
    xy_bad = 0; rgb_bad = 0; sync_bad = 0;
    pt_bad = 0; vc_bad = 0;
    hs_lo = 0; hs_first = -1;
    bn_cnt = 0; bn_first = -1; bn_last = -1;
    g_cnt = 0; line_ticks = 0; d_fs_n = 0;
    s_fs_n = 0; s_fs_first = -1; s_fs_bad = 0;
    s_vs_lo = 0; s_vs_first = -1;

    while (n <= 9900 && c < 30000) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (d_vc != ((c % 2) == 0)) vc_bad++;
      if (d_pt != ((c % 2) == 0)) pt_bad++;
      if (c == 1) check("e1_pt", int'(d_pt), 0);
      if (c == 2) check("e2_pt", int'(d_pt), 1);
      if (c == 2) check("e2_x", int'(d_x), 0);
      if (c == 3) check("e3_x", int'(d_x), 1);
      if (c == 5) check("e5_x", int'(d_x), 2);
      if (d_fs) d_fs_n++;
      if (s_fs) begin
        if (!s_pt) s_fs_bad++;
        if (s_fs_n == 0) s_fs_first = n;
        s_fs_n++;
      end
      if (d_pt) begin
        px = n % 800;
        py = n / 800;
        if (int'(d_x) != px || int'(d_y) != py) xy_bad++;
        ppx = (n - 1) % 800;
        ppy = (n - 1) / 800;
        pact = (n > 0) && ppx < 640 && ppy < 480;
        ehs = !((n > 0) && ppx >= 656 && ppx < 752);
        evs = !((n > 0) && ppy >= 490 && ppy < 492);
        if (d_bn != pact) rgb_bad++;
        if (int'(d_r) != (pact ? ppx % 256 : 0)) rgb_bad++;
        if (int'(d_g) != (pact ? 255 : 0)) rgb_bad++;
        if (int'(d_b) != (pact ? ppy % 256 : 0)) rgb_bad++;
        if (d_hs != ehs || d_vs != evs) sync_bad++;
        if (n < 800) begin
          if (!d_hs) begin
            hs_lo++;
            if (hs_first < 0) hs_first = px;
          end
          if (d_bn) begin
            bn_cnt++;
            if (bn_first < 0) bn_first = px;
            bn_last = px;
          end
          if (d_g == 8'hFF) g_cnt++;
        end
        if (n < 1600 && d_y == 10'd0) line_ticks++;
        if (n == 799) begin
          check("x_799", int'(d_x), 799);
          check("y_799", int'(d_y), 0);
        end
        if (n == 800) begin
          check("x_wrap", int'(d_x), 0);
          check("y_inc", int'(d_y), 1);
        end
        if (n == 8038) begin
          check("align_r37", int'(d_r), 37);
          check("align_b10", int'(d_b), 10);
          check("align_bn", int'(d_bn), 1);
        end
        if (n < 360 && !s_vs) begin
          s_vs_lo++;
          if (s_vs_first < 0) s_vs_first = n;
        end
        n++;
      end
    end

    // abort mid-frame, between clock edges
    #4 rst = 1'b1;
    #1;
    check("budget1", n, 9901);
    check("abort_hs", int'(d_hs), 1);
    check("abort_vs", int'(d_vs), 1);
    check("abort_bn", int'(d_bn), 0);
    check("abort_g", int'(d_g), 0);
    check("abort_r", int'(d_r), 0);
    check("abort_x", int'(d_x), 0);
    check("abort_y", int'(d_y), 0);
    check("abort_pt", int'(d_pt), 0);
    check("abort_s_x", int'(s_x), 0);
    check("abort_s_bn", int'(s_bn), 0);

    check("hs_low_ticks", hs_lo, 96);
    check("hs_first_x", hs_first, 657);
    check("bn_ticks", bn_cnt, 640);
    check("bn_first_x", bn_first, 1);
    check("bn_last_x", bn_last, 640);
    check("g_ff_ticks", g_cnt, 640);
    check("line_ticks", line_ticks, 800);
    check("xy_seq", xy_bad, 0);
    check("rgb_seq", rgb_bad, 0);
    check("sync_seq", sync_bad, 0);
    check("pt_period", pt_bad, 0);
    check("vclk_toggle", vc_bad, 0);
    check("big_fs", d_fs_n, 0);
    check("s_fs_count", s_fs_n, 27);
    check("s_fs_first", s_fs_first, 359);
    check("s_fs_w_pt", s_fs_bad, 0);
    check("s_vs_low", s_vs_lo, 48);
    check("s_vs_first", s_vs_first, 241);

    @(negedge clk);
    @(negedge clk);
    #5 rst = 1'b0;

    c = 0; n = 0;
    xy_bad = 0; d_fs_n = 0;
    s_fs_n = 0; s_fs_first = -1;
    while (n < 400 && c < 2000) begin
      @(posedge clk);
      @(negedge clk);
      c++;
      if (d_fs) d_fs_n++;
      if (s_fs) begin
        if (s_fs_n == 0) s_fs_first = n;
        s_fs_n++;
      end
      if (d_pt) begin
        if (int'(d_x) != n || d_y != 10'd0) xy_bad++;
        if (int'(s_x) != n % 24) xy_bad++;
        if (int'(s_y) != (n / 24) % 15) xy_bad++;
        n++;
      end
    end
    check("budget2", n, 400);
    check("restart_xy", xy_bad, 0);
    check("restart_fs_n", s_fs_n, 1);
    check("restart_fs_at", s_fs_first, 359);
    check("restart_big_fs", d_fs_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
